// File: rtl/window_scan_ctrl.sv
// Raster-scan sequencer for a KERNEL x KERNEL convolution window.
// Drives the parallel_out_sr load controls and tags each complete window with its top-left coordinate.
module window_scan_ctrl #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int KERNEL     = 3,
    parameter int COL_W      = 8,
    parameter int ROW_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             pixel_valid,
    output logic             pixel_ready,
    output logic             sr_enable,
    output logic             sr_shift_row_up,
    output logic             window_valid,
    input  logic             window_ready,
    output logic [COL_W-1:0] win_col,
    output logic [ROW_W-1:0] win_row,
    output logic             busy,
    output logic             frame_done
);
    // state | meaning
    // IDLE  | waiting for start, no pixels accepted
    // FILL  | priming rows 0..KERNEL-2, shift only
    // RUN   | rows KERNEL-1..IMG_HEIGHT-1, row-up load, windows emitted
    // DONE  | draining last window, then frame_done pulse
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_KOFF  = COL_W'(KERNEL - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_FILLED = ROW_W'(KERNEL - 2);
    localparam logic [ROW_W-1:0] ROW_KOFF  = ROW_W'(KERNEL - 1);

    logic [1:0]       state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             col_wrap;
    logic             load_win;

    assign pixel_ready     = ((state == S_FILL) || (state == S_RUN)) && !(window_valid && !window_ready);
    assign accept          = pixel_valid && pixel_ready;
    assign sr_enable       = accept;
    assign sr_shift_row_up = accept && (state == S_RUN);
    assign busy            = (state != S_IDLE);
    assign col_wrap        = (col == COL_LAST);
    // a window is complete once the last KERNEL columns of a RUN row are loaded
    assign load_win        = accept && (state == S_RUN) && (col >= COL_KOFF);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_FILL;
                S_FILL: if (accept && col_wrap && (row == ROW_FILLED)) state <= S_RUN;
                S_RUN:  if (accept && col_wrap && (row == ROW_LAST)) state <= S_DONE;
                S_DONE: if (frame_done) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if ((state == S_IDLE) && start) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_wrap) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            window_valid <= 1'b0;
            win_col      <= '0;
            win_row      <= '0;
        end else if (load_win) begin
            window_valid <= 1'b1;
            win_col      <= col - COL_KOFF;
            win_row      <= row - ROW_KOFF;
        end else if (window_ready) begin
            window_valid <= 1'b0;
        end
    end

    // pulse is raised while still in DONE so a coincident start is ignored
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == S_DONE) && !frame_done && (!window_valid || window_ready);
        end
    end
endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl with a 4x4 image and 3x3 kernel.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_window_scan_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pixel_valid = 1'b0;
    logic       pixel_ready;
    logic       sr_enable;
    logic       sr_shift_row_up;
    logic       window_valid;
    logic       window_ready = 1'b1;
    logic [7:0] win_col;
    logic [7:0] win_row;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int failures = 0;

    int exp_col[4] = '{0, 1, 0, 1};
    int exp_row[4] = '{0, 0, 1, 1};

    int obs_col[8];
    int obs_row[8];
    int n_acc, n_up, shift_viol, en_viol, n_win, last_win_cyc, done_cyc, n_done;
    int first_ready_cyc, stall_cycles, stall_viol, timed_out;
    logic post_busy, post_fd;

    window_scan_ctrl #(
        .IMG_WIDTH(4), .IMG_HEIGHT(4), .KERNEL(3), .COL_W(8), .ROW_W(8)
    ) dut (
        .clock(clock), .reset(reset), .start(start),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
        .sr_enable(sr_enable), .sr_shift_row_up(sr_shift_row_up),
        .window_valid(window_valid), .window_ready(window_ready),
        .win_col(win_col), .win_row(win_row),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    // mode: 0 continuous, 1 stall after first window, 2 bubbles, 3 stray start, 4 reset mid-RUN
    task automatic run_frame(input int mode);
        int stall_left = 0;
        int stall_started = 0;
        int finished = 0;
        n_acc = 0; n_up = 0; shift_viol = 0; en_viol = 0; n_win = 0;
        last_win_cyc = 0; done_cyc = 0; n_done = 0; first_ready_cyc = 0;
        stall_cycles = 0; stall_viol = 0; timed_out = 0;
        post_busy = 1'bx; post_fd = 1'bx;
        for (int i = 0; i < 8; i++) begin obs_col[i] = -1; obs_row[i] = -1; end
        for (int cyc = 1; cyc <= 60 && finished == 0; cyc++) begin
            @(posedge clock); #1;
            if (mode == 4 && cyc == 11) begin
                reset = 1'b1; start = 1'b0; pixel_valid = 1'b0; window_ready = 1'b0;
                @(negedge clock);
                return;
            end
            start = (cyc == 1) || (mode == 3 && cyc == 12);
            pixel_valid = (mode == 2) ? (cyc % 2 == 0) : 1'b1;
            if (mode == 1 && stall_started == 0 && window_valid) begin
                stall_started = 1; stall_left = 5;
            end
            window_ready = (stall_left == 0);
            @(negedge clock);
            if (pixel_ready && first_ready_cyc == 0) first_ready_cyc = cyc;
            if (sr_enable !== (pixel_valid & pixel_ready)) en_viol++;
            if (sr_enable === 1'b1) begin
                if (sr_shift_row_up !== (n_acc >= 8)) shift_viol++;
                if (sr_shift_row_up) n_up++;
                n_acc++;
            end else if (sr_shift_row_up !== 1'b0) begin
                shift_viol++;
            end
            if (stall_left > 0) begin
                stall_cycles++;
                if (window_valid !== 1'b1 || pixel_ready !== 1'b0 || sr_enable !== 1'b0 ||
                    win_col !== 8'd0 || win_row !== 8'd0) stall_viol++;
                stall_left--;
            end
            if (window_valid && window_ready) begin
                if (n_win < 8) begin obs_col[n_win] = int'(win_col); obs_row[n_win] = int'(win_row); end
                n_win++;
                last_win_cyc = cyc;
            end
            if (done_cyc != 0 && cyc == done_cyc + 1) begin
                post_busy = busy; post_fd = frame_done; finished = 1;
            end
            if (frame_done) begin
                n_done++;
                if (done_cyc == 0) done_cyc = cyc;
            end
        end
        if (finished == 0) timed_out = 1;
        start = 1'b0; pixel_valid = 1'b0; window_ready = 1'b1;
    endtask

    task automatic test_reset;
        @(posedge clock); #1;
        start = 1'b1; pixel_valid = 1'b1; window_ready = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (11) @(posedge clock);
        @(negedge clock);
        checks++;
        if (window_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_precond: window_valid=%0b busy=%0b expected 1 1", window_valid, busy);
        end
        start = 1'b1;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({pixel_ready, sr_enable, sr_shift_row_up, window_valid, busy, frame_done} !== 6'b0 ||
            win_col !== 8'd0 || win_row !== 8'd0) begin
            failures++;
            $display("FAIL reset_async: rdy=%0b en=%0b up=%0b wv=%0b busy=%0b fd=%0b col=%0d row=%0d expected all 0",
                     pixel_ready, sr_enable, sr_shift_row_up, window_valid, busy, frame_done, win_col, win_row);
        end
        @(posedge clock); @(negedge clock);
        checks++;
        if (busy !== 1'b0 || pixel_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_held: busy=%0b pixel_ready=%0b expected 0 0", busy, pixel_ready);
        end
        start = 1'b0; pixel_valid = 1'b0; window_ready = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic test_full_frame;
        run_frame(0);
        checks++;
        if (first_ready_cyc !== 2) begin
            failures++; $display("FAIL full_first_ready: cycle=%0d expected 2", first_ready_cyc);
        end
        checks++;
        if (n_acc !== 16 || n_up !== 8 || shift_viol !== 0 || en_viol !== 0) begin
            failures++;
            $display("FAIL full_accepts: acc=%0d up=%0d shift_err=%0d en_err=%0d expected 16 8 0 0",
                     n_acc, n_up, shift_viol, en_viol);
        end
        checks++;
        if (n_win !== 4) begin failures++; $display("FAIL full_win_count: got %0d expected 4", n_win); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_col[i] !== exp_col[i] || obs_row[i] !== exp_row[i]) begin
                failures++;
                $display("FAIL full_win%0d: got (%0d,%0d) expected (%0d,%0d)", i, obs_col[i], obs_row[i], exp_col[i], exp_row[i]);
            end
        end
        checks++;
        if (last_win_cyc !== 18 || done_cyc !== 19 || n_done !== 1 || timed_out !== 0) begin
            failures++;
            $display("FAIL full_done_timing: last_win=%0d done=%0d pulses=%0d timeout=%0d expected 18 19 1 0",
                     last_win_cyc, done_cyc, n_done, timed_out);
        end
        checks++;
        if (post_busy !== 1'b0 || post_fd !== 1'b0) begin
            failures++; $display("FAIL full_idle_after: busy=%0b fd=%0b expected 0 0", post_busy, post_fd);
        end
    endtask

    task automatic test_backpressure;
        run_frame(1);
        checks++;
        if (stall_cycles !== 5 || stall_viol !== 0) begin
            failures++;
            $display("FAIL bp_hold: stall_cycles=%0d violations=%0d expected 5 0", stall_cycles, stall_viol);
        end
        checks++;
        if (n_win !== 4 || n_acc !== 16 || en_viol !== 0) begin
            failures++; $display("FAIL bp_counts: win=%0d acc=%0d en_err=%0d expected 4 16 0", n_win, n_acc, en_viol);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_col[i] !== exp_col[i] || obs_row[i] !== exp_row[i]) begin
                failures++;
                $display("FAIL bp_win%0d: got (%0d,%0d) expected (%0d,%0d)", i, obs_col[i], obs_row[i], exp_col[i], exp_row[i]);
            end
        end
        checks++;
        if (done_cyc !== 24) begin failures++; $display("FAIL bp_done: cycle=%0d expected 24", done_cyc); end
    endtask

    task automatic test_bubbles;
        run_frame(2);
        checks++;
        if (n_acc !== 16 || n_up !== 8 || en_viol !== 0 || shift_viol !== 0) begin
            failures++;
            $display("FAIL bub_accepts: acc=%0d up=%0d en_err=%0d shift_err=%0d expected 16 8 0 0",
                     n_acc, n_up, en_viol, shift_viol);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_col[i] !== exp_col[i] || obs_row[i] !== exp_row[i]) begin
                failures++;
                $display("FAIL bub_win%0d: got (%0d,%0d) expected (%0d,%0d)", i, obs_col[i], obs_row[i], exp_col[i], exp_row[i]);
            end
        end
        checks++;
        if (n_win !== 4 || done_cyc !== 34) begin
            failures++; $display("FAIL bub_done: win=%0d done=%0d expected 4 34", n_win, done_cyc);
        end
    endtask

    task automatic test_stray_start;
        run_frame(3);
        checks++;
        if (n_win !== 4 || n_acc !== 16 || done_cyc !== 19 || n_done !== 1) begin
            failures++;
            $display("FAIL stray_frame: win=%0d acc=%0d done=%0d pulses=%0d expected 4 16 19 1",
                     n_win, n_acc, done_cyc, n_done);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_col[i] !== exp_col[i] || obs_row[i] !== exp_row[i]) begin
                failures++;
                $display("FAIL stray_win%0d: got (%0d,%0d) expected (%0d,%0d)", i, obs_col[i], obs_row[i], exp_col[i], exp_row[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        run_frame(4);
        checks++;
        if (n_acc !== 9 || n_win !== 0) begin
            failures++; $display("FAIL midrst_progress: acc=%0d win=%0d expected 9 0", n_acc, n_win);
        end
        checks++;
        if (window_valid !== 1'b0 || busy !== 1'b0 || pixel_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_abort: wv=%0b busy=%0b rdy=%0b expected 0 0 0", window_valid, busy, pixel_ready);
        end
        window_ready = 1'b1;
        #2 reset = 1'b0;
        run_frame(0);
        checks++;
        if (n_win !== 4 || n_acc !== 16 || done_cyc !== 19) begin
            failures++;
            $display("FAIL midrst_restart: win=%0d acc=%0d done=%0d expected 4 16 19", n_win, n_acc, done_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_col[i] !== exp_col[i] || obs_row[i] !== exp_row[i]) begin
                failures++;
                $display("FAIL midrst_win%0d: got (%0d,%0d) expected (%0d,%0d)", i, obs_col[i], obs_row[i], exp_col[i], exp_row[i]);
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_full_frame();
        test_backpressure();
        test_bubbles();
        test_stray_start();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
